// File: rtl/tail_lamp_monitor.sv
// rtl/tail_lamp_monitor.sv - passive rear-lamp bus checker: sweep/brake decode, sweep counters, sticky fault
module tail_lamp_monitor #(
    parameter int DWELL_MAX    = 4,
    parameter int CLEAR_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic             clka,
    input  logic             RESTART,
    input  logic [2:0]       L,
    input  logic [2:0]       R,
    output logic             BRAKE_ON,
    output logic             TURN_LEFT,
    output logic             TURN_RIGHT,
    output logic             FAULT,
    output logic [CNT_W-1:0] LEFT_CNT,
    output logic [CNT_W-1:0] RIGHT_CNT,
    output logic [CNT_W-1:0] FAULT_CNT
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LS1  = 3'd1,
        LS2  = 3'd2,
        RS1  = 3'd3,
        RS2  = 3'd4,
        FLT  = 3'd5
    } state_t;

    // dwell counts repeats of the current sweep pattern, so the last allowed repeat is DWELL_MAX-1
    localparam logic [3:0] DWELL_LAST = 4'(DWELL_MAX - 1);
    localparam logic [3:0] CLEAR_LAST = 4'(CLEAR_CYCLES - 1);

    state_t     state;
    logic [3:0] dwell;
    logic [3:0] clr;
    logic       go_flt;

    logic       l_steady;
    logic       r_steady;
    logic       in_right;
    logic [2:0] mine;
    logic [2:0] other;
    logic       other_steady;
    logic [2:0] first_pat;
    logic [2:0] second_pat;
    logic       dwell_full;
    logic [CNT_W-1:0] fault_cnt_next;

    assign l_steady     = (L == 3'b000) || (L == 3'b111);
    assign r_steady     = (R == 3'b000) || (R == 3'b111);
    assign in_right     = (state == RS1) || (state == RS2);
    assign mine         = in_right ? R : L;
    assign other        = in_right ? L : R;
    assign other_steady = in_right ? l_steady : r_steady;
    assign first_pat    = in_right ? 3'b100 : 3'b001;
    assign second_pat   = in_right ? 3'b110 : 3'b011;
    assign dwell_full   = (dwell == DWELL_LAST);
    assign fault_cnt_next = (FAULT_CNT == {CNT_W{1'b1}}) ? FAULT_CNT : FAULT_CNT + 1'b1;

    // decide whether the current sample is a sequence the controller must never produce
    always_comb begin
        go_flt = 1'b0;
        case (state)
            IDLE:     go_flt = !(l_steady && r_steady) &&
                               !((L == 3'b001) && r_steady) &&
                               !((R == 3'b100) && l_steady);
            LS1, RS1: go_flt = !other_steady ||
                               !(((mine == first_pat) && !dwell_full) || (mine == second_pat));
            LS2, RS2: go_flt = !other_steady ||
                               !(((mine == second_pat) && !dwell_full) || (mine == 3'b111));
            default:  go_flt = 1'b0;
        endcase
    end

    // sweep/fault state machine with registered decode outputs and counters
    always_ff @(posedge clka or posedge RESTART) begin
        if (RESTART) begin
            state      <= IDLE;
            dwell      <= 4'd0;
            clr        <= 4'd0;
            BRAKE_ON   <= 1'b0;
            TURN_LEFT  <= 1'b0;
            TURN_RIGHT <= 1'b0;
            FAULT      <= 1'b0;
            LEFT_CNT   <= '0;
            RIGHT_CNT  <= '0;
            FAULT_CNT  <= '0;
        end else begin
            TURN_LEFT  <= 1'b0;
            TURN_RIGHT <= 1'b0;
            if (go_flt) begin
                state     <= FLT;
                FAULT     <= 1'b1;
                BRAKE_ON  <= 1'b0;
                dwell     <= 4'd0;
                clr       <= 4'd0;
                FAULT_CNT <= fault_cnt_next;
            end else begin
                case (state)
                    IDLE: begin
                        if (l_steady && r_steady) begin
                            // mixed 111/000 keeps the previous brake level
                            if ((L == 3'b111) && (R == 3'b111)) begin
                                BRAKE_ON <= 1'b1;
                            end else if ((L == 3'b000) && (R == 3'b000)) begin
                                BRAKE_ON <= 1'b0;
                            end
                        end else if (L == 3'b001) begin
                            state    <= LS1;
                            dwell    <= 4'd0;
                            BRAKE_ON <= (R == 3'b111);
                        end else begin
                            state    <= RS1;
                            dwell    <= 4'd0;
                            BRAKE_ON <= (L == 3'b111);
                        end
                    end
                    LS1, RS1: begin
                        BRAKE_ON <= (other == 3'b111);
                        if (mine == first_pat) begin
                            dwell <= dwell + 4'd1;
                        end else begin
                            state <= in_right ? RS2 : LS2;
                            dwell <= 4'd0;
                        end
                    end
                    LS2, RS2: begin
                        BRAKE_ON <= (other == 3'b111);
                        if (mine == second_pat) begin
                            dwell <= dwell + 4'd1;
                        end else begin
                            state <= IDLE;
                            dwell <= 4'd0;
                            if (in_right) begin
                                TURN_RIGHT <= 1'b1;
                                RIGHT_CNT  <= RIGHT_CNT + 1'b1;
                            end else begin
                                TURN_LEFT <= 1'b1;
                                LEFT_CNT  <= LEFT_CNT + 1'b1;
                            end
                        end
                    end
                    FLT: begin
                        BRAKE_ON <= 1'b0;
                        if ((L == 3'b000) && (R == 3'b000)) begin
                            if (clr == CLEAR_LAST) begin
                                state <= IDLE;
                                FAULT <= 1'b0;
                                clr   <= 4'd0;
                            end else begin
                                clr <= clr + 4'd1;
                            end
                        end else begin
                            clr <= 4'd0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tail_lamp_monitor.sv
// tb/tb_tail_lamp_monitor.sv - randomized scoreboard bench for tail_lamp_monitor
module tb_tail_lamp_monitor;

    localparam int DW = 4;
    localparam int CC = 2;
    localparam int CW = 8;

    logic          clka = 1'b0;
    logic          RESTART;
    logic [2:0]    L;
    logic [2:0]    R;
    logic          BRAKE_ON;
    logic          TURN_LEFT;
    logic          TURN_RIGHT;
    logic          FAULT;
    logic [CW-1:0] LEFT_CNT;
    logic [CW-1:0] RIGHT_CNT;
    logic [CW-1:0] FAULT_CNT;

    tail_lamp_monitor #(
        .DWELL_MAX   (DW),
        .CLEAR_CYCLES(CC),
        .CNT_W       (CW)
    ) dut (
        .clka      (clka),
        .RESTART   (RESTART),
        .L         (L),
        .R         (R),
        .BRAKE_ON  (BRAKE_ON),
        .TURN_LEFT (TURN_LEFT),
        .TURN_RIGHT(TURN_RIGHT),
        .FAULT     (FAULT),
        .LEFT_CNT  (LEFT_CNT),
        .RIGHT_CNT (RIGHT_CNT),
        .FAULT_CNT (FAULT_CNT)
    );

    always #10 clka = ~clka;

    typedef struct {
        int brake;
        int tl;
        int tr;
        int flt;
        int lc;
        int rc;
        int fc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // reference model: mode 0 idle, 1 left sweep, 2 right sweep, 3 fault
    int mode, stage, run, clr_run, m_brake, lcnt, rcnt, fcnt;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit steady(input int x);
        return (x == 0) || (x == 7);
    endfunction

    task automatic model_reset();
        mode = 0; stage = 0; run = 0; clr_run = 0;
        m_brake = 0; lcnt = 0; rcnt = 0; fcnt = 0;
    endtask

    task automatic enter_fault();
        mode = 3;
        m_brake = 0;
        clr_run = 0;
        if (fcnt < (1 << CW) - 1) fcnt++;
    endtask

    task automatic model_sample(input int l, input int r, output exp_t e);
        int mine, other, hold_p, next_p;
        e.tl = 0;
        e.tr = 0;
        case (mode)
            0: begin
                if (steady(l) && steady(r)) begin
                    if (l == 7 && r == 7) m_brake = 1;
                    else if (l == 0 && r == 0) m_brake = 0;
                end else if (l == 1 && steady(r)) begin
                    mode = 1; stage = 1; run = 1; m_brake = (r == 7);
                end else if (r == 4 && steady(l)) begin
                    mode = 2; stage = 1; run = 1; m_brake = (l == 7);
                end else begin
                    enter_fault();
                end
            end
            1, 2: begin
                mine   = (mode == 1) ? l : r;
                other  = (mode == 1) ? r : l;
                hold_p = (mode == 1) ? ((stage == 1) ? 1 : 3) : ((stage == 1) ? 4 : 6);
                next_p = (mode == 1) ? ((stage == 1) ? 3 : 7) : ((stage == 1) ? 6 : 7);
                if (!steady(other)) begin
                    enter_fault();
                end else if (mine == hold_p) begin
                    run++;
                    if (run > DW) enter_fault();
                    else m_brake = (other == 7);
                end else if (mine == next_p) begin
                    m_brake = (other == 7);
                    if (stage == 1) begin
                        stage = 2; run = 1;
                    end else begin
                        if (mode == 1) begin e.tl = 1; lcnt = (lcnt + 1) % (1 << CW); end
                        else begin e.tr = 1; rcnt = (rcnt + 1) % (1 << CW); end
                        mode = 0;
                    end
                end else begin
                    enter_fault();
                end
            end
            default: begin
                if (l == 0 && r == 0) begin
                    clr_run++;
                    if (clr_run == CC) mode = 0;
                end else begin
                    clr_run = 0;
                end
            end
        endcase
        e.brake = m_brake;
        e.flt   = (mode == 3);
        e.lc    = lcnt;
        e.rc    = rcnt;
        e.fc    = fcnt;
    endtask

    // drive one sample for the next rising edge and queue the response it must produce
    task automatic step(input int l, input int r);
        exp_t e;
        @(negedge clka);
        L = l[2:0];
        R = r[2:0];
        model_sample(l, r, e);
        q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_brake"}, BRAKE_ON, 0);
        chk({tag, "_tl"}, TURN_LEFT, 0);
        chk({tag, "_tr"}, TURN_RIGHT, 0);
        chk({tag, "_fault"}, FAULT, 0);
        chk({tag, "_lcnt"}, LEFT_CNT, 0);
        chk({tag, "_rcnt"}, RIGHT_CNT, 0);
        chk({tag, "_fcnt"}, FAULT_CNT, 0);
    endtask

    // asynchronous reset pulse between clock edges, outputs checked before the next edge
    task automatic do_reset();
        @(posedge clka);
        #5 RESTART = 1'b1;
        #1 check_all_zero("reset");
        model_reset();
        #2 RESTART = 1'b0;
    endtask

    task automatic sweep(input bit right, input int oth, input int n1, input int n2, input int last);
        for (int i = 0; i < n1; i++) step(right ? oth : 1, right ? 4 : oth);
        for (int i = 0; i < n2; i++) step(right ? oth : 3, right ? 6 : oth);
        step(right ? oth : last, right ? last : oth);
    endtask

    // monitor: every edge that had a queued sample is compared shortly after the edge
    always @(posedge clka) begin
        exp_t e;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("brake_on", BRAKE_ON, e.brake);
            chk("turn_left", TURN_LEFT, e.tl);
            chk("turn_right", TURN_RIGHT, e.tr);
            chk("fault", FAULT, e.flt);
            chk("left_cnt", LEFT_CNT, e.lc);
            chk("right_cnt", RIGHT_CNT, e.rc);
            chk("fault_cnt", FAULT_CNT, e.fc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, oth, last;
        RESTART = 1'b1;
        L = 3'd0;
        R = 3'd0;
        model_reset();
        repeat (2) @(negedge clka);
        check_all_zero("init");
        @(posedge clka);
        #8 RESTART = 1'b0;

        // left sweep without brake
        step(0, 0);
        sweep(1'b0, 0, 1, 1, 7);
        // right sweep with brake held on the left side
        step(7, 0);
        sweep(1'b1, 7, 1, 1, 7);
        step(0, 0);
        // illegal pattern then clear with an interruption
        step(1, 4);
        step(0, 0);
        step(5, 5);
        step(0, 0);
        step(0, 0);
        // dwell limit: 4 repeats legal, 5 faults
        sweep(1'b0, 0, 4, 1, 7);
        for (int i = 0; i < 5; i++) step(1, 0);
        step(0, 0);
        step(0, 0);
        // back-to-back sweeps wrap the left counter
        do_reset();
        for (int i = 0; i < 256; i++) sweep(1'b0, 0, 1, 1, 7);
        @(posedge clka);
        #3;
        chk("wrap_left_cnt", LEFT_CNT, 0);
        chk("wrap_right_cnt", RIGHT_CNT, 0);
        // reset in the middle of a sweep
        do_reset();
        for (int i = 0; i < 3; i++) sweep(1'b0, 0, 1, 1, 7);
        step(1, 0);
        step(3, 0);
        do_reset();
        step(3, 0);
        step(7, 0);
        step(0, 0);
        step(0, 0);

        // randomized mix of legal sweeps, arbitrary patterns and all-off runs
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 9);
            if (k < 6) begin
                oth  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : ($urandom_range(0, 1) ? 7 : 0);
                last = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : 7;
                sweep(1'($urandom_range(0, 1)), oth, $urandom_range(1, DW + 1),
                      $urandom_range(1, DW + 1), last);
            end else if (k < 8) begin
                step($urandom_range(0, 7), $urandom_range(0, 7));
            end else begin
                for (int i = 0; i < int'($urandom_range(1, 3)); i++) step(0, 0);
            end
        end

        repeat (3) @(posedge clka);
        #5;
        chk("queue_drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
